// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline-register controls shared between the
// stall/flush controller and the pipeline datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             Branch_Taken;
  logic             MDU_Start;
  logic             Ext_Hold;
  logic             PC_En;
  logic             IFID_En;
  logic             IFID_Flush;
  logic             IDEX_En;
  logic             IDEX_Flush;
  logic             EXMEM_En;
  logic             EXMEM_Flush;
  logic             MDU_Busy;
  logic [CNT_W-1:0] Stall_Cnt;

  modport master (
    output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, Branch_Taken, MDU_Start, Ext_Hold,
    input  PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_En, EXMEM_Flush,
    input  MDU_Busy, Stall_Cnt
  );

  modport slave (
    input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, Branch_Taken, MDU_Start, Ext_Hold,
    output PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_En, EXMEM_Flush,
    output MDU_Busy, Stall_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: fixed-priority resolution of memory holds,
// MDU occupancy, taken branches and load-use hazards, plus a stall counter.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic Clk,
  input  logic Rst_N,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       mdu_cnt_reg, mdu_cnt_next;
  logic             mdu_busy_reg, mdu_busy_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic load_use;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                    ((hz.IDEX_Rt == hz.IFID_Rs) || (hz.IDEX_Rt == hz.IFID_Rt));

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_en       = 1'b1;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    exmem_flush   = 1'b0;
    state_next    = state_reg;
    mdu_cnt_next  = mdu_cnt_reg;
    mdu_busy_next = mdu_busy_reg;

    if (hz.Ext_Hold) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (state_reg == MDU_WAIT) begin
      // EX still holds the MDU op; feed bubbles into MEM until it retires
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_flush  = 1'b1;
      mdu_cnt_next = mdu_cnt_reg - 4'd1;
      if (mdu_cnt_reg == 4'd1) begin
        state_next    = RUN;
        mdu_busy_next = 1'b0;
      end
    end else if (hz.Branch_Taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hz.MDU_Start) begin
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmem_flush   = 1'b1;
      state_next    = MDU_WAIT;
      mdu_cnt_next  = 4'(MDU_LAT - 1);
      mdu_busy_next = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_reg     <= RUN;
      mdu_cnt_reg   <= 4'd0;
      mdu_busy_reg  <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mdu_cnt_reg  <= mdu_cnt_next;
      mdu_busy_reg <= mdu_busy_next;
      if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  // Controls are forced inactive while reset is asserted
  assign hz.PC_En       = pc_en       & Rst_N;
  assign hz.IFID_En     = ifid_en     & Rst_N;
  assign hz.IFID_Flush  = ifid_flush  & Rst_N;
  assign hz.IDEX_En     = idex_en     & Rst_N;
  assign hz.IDEX_Flush  = idex_flush  & Rst_N;
  assign hz.EXMEM_En    = exmem_en    & Rst_N;
  assign hz.EXMEM_Flush = exmem_flush & Rst_N;
  assign hz.MDU_Busy    = mdu_busy_reg;
  assign hz.Stall_Cnt   = stall_cnt_reg;

endmodule
